// File: rtl/grain_stream_decryptor.sv
// -----------------------------------------------------------------------------
// grain_stream_decryptor
//
// Consumer end of a Grain keystream generator. Keys the generator (parallel
// seed load followed by a warm-up run whose bits are thrown away), then
// decrypts ciphertext bytes. For each byte it pulls DATA_W keystream bits
// MSB first, XORs them with the byte and presents the plaintext downstream.
//
// Ports
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   start, seed   : one-cycle rekey pulse and the key/IV sampled with it
//   ks_par_load   : parallel-load strobe to the generator
//   ks_seed       : seed presented to the generator
//   ks_shift_en   : advance the generator one bit this cycle
//   ks_bit        : generator keystream bit (valid while ks_shift_en=1)
//   ct_data/ct_valid/ct_ready : ciphertext byte handshake (input side)
//   pt_data/pt_valid/pt_ready : plaintext byte handshake (output side)
//   busy          : high in every state except IDLE and READY
// -----------------------------------------------------------------------------
module grain_stream_decryptor #(
    parameter int SEED_W = 105,
    parameter int WARMUP = 160,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    output logic              ks_par_load,
    output logic [SEED_W-1:0] ks_seed,
    output logic              ks_shift_en,
    input  logic              ks_bit,
    input  logic [DATA_W-1:0] ct_data,
    input  logic              ct_valid,
    output logic              ct_ready,
    output logic [DATA_W-1:0] pt_data,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic              busy
);

    // One counter serves both the warm-up run and the per-byte bit count,
    // so it is sized for the longer of the two phases.
    localparam int CNT_MAX = (WARMUP > DATA_W) ? WARMUP : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WARM  = 3'd2,
        READY = 3'd3,
        GEN   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] ct_lat;
    logic [DATA_W-1:0] ks_byte;
    logic [DATA_W-1:0] ks_next;

    // The first keystream bit of a byte ends up in the MSB: every new bit
    // enters at bit 0 and pushes the earlier ones upward.
    function automatic logic [DATA_W-1:0] shift_in_bit(
        input logic [DATA_W-1:0] cur,
        input logic              b
    );
        return (cur << 1) | DATA_W'(b);
    endfunction

    always_comb begin
        ks_next = shift_in_bit(ks_byte, ks_bit);
    end

    // Moore outputs, decoded from the registered state only.
    assign ks_par_load = (state == LOAD);
    assign ks_shift_en = (state == WARM) || (state == GEN);
    assign ct_ready    = (state == READY);
    assign busy        = (state != IDLE) && (state != READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ks_seed  <= '0;
            ct_lat   <= '0;
            ks_byte  <= '0;
            pt_data  <= '0;
            pt_valid <= 1'b0;
        end else if (start) begin
            // Rekey wins over everything: any byte in flight or waiting
            // downstream is abandoned.
            state    <= LOAD;
            ks_seed  <= seed;
            cnt      <= '0;
            ks_byte  <= '0;
            pt_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= IDLE;
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= (WARMUP == 0) ? READY : WARM;
                end
                WARM: begin
                    if (cnt == WARM_LAST) begin
                        cnt   <= '0;
                        state <= READY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (ct_valid) begin
                        ct_lat <= ct_data;
                        cnt    <= '0;
                        state  <= GEN;
                    end
                end
                GEN: begin
                    ks_byte <= ks_next;
                    if (cnt == GEN_LAST) begin
                        cnt      <= '0;
                        pt_data  <= ct_lat ^ ks_next;
                        pt_valid <= 1'b1;
                        state    <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (pt_ready) begin
                        pt_valid <= 1'b0;
                        state    <= READY;
                    end
                end
                default: begin
                    state    <= IDLE;
                    pt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
